// File: rtl/commit_trace_buffer.sv
// Commit-event capture stage for the RV32I datapath: stamps register-writeback and
// store commits with PC and cycle count, buffers them in a FWFT FIFO drained over valid/ready.
module commit_trace_buffer #(
    parameter int DEPTH      = 16,
    parameter int MAX_CYCLES = 2000,
    parameter bit FILTER_X0  = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     trace_en,
    input  logic                     reg_we,
    input  logic [4:0]               reg_idx,
    input  logic [31:0]              reg_wdata,
    input  logic                     mem_we,
    input  logic [31:0]              mem_addr,
    input  logic [31:0]              mem_wdata,
    input  logic [31:0]              pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_type,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_tag,
    output logic [31:0]              out_data,
    output logic [31:0]              out_cycle,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              dropped,
    output logic                     overflow,
    output logic                     both_err,
    output logic                     timeout
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = 129;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    // Entry layout: {type, pc, tag, data, cycle}
    logic [EW-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [15:0]   dropped_q, dropped_d;
    logic [31:0]   cycle_q, cycle_d;
    logic          overflow_q, overflow_d;
    logic          both_err_q, both_err_d;
    logic          timeout_q, timeout_d;

    logic          reg_evt, mem_evt, push_req, pop, push_ok;
    logic [EW-1:0] push_entry;
    logic [EW-1:0] head_entry;

    always_comb begin
        reg_evt  = trace_en && reg_we && !(FILTER_X0 && (reg_idx == 5'd0));
        mem_evt  = trace_en && mem_we;
        push_req = reg_evt || mem_evt;
        pop      = (level_q != '0) && out_ready;
        // A full FIFO still accepts when the head leaves on the same edge
        push_ok  = push_req && ((level_q != FULL_LVL) || pop);

        // REG wins a simultaneous commit; the store is discarded without counting as a drop
        if (reg_evt) begin
            push_entry = {1'b0, pc, {27'd0, reg_idx}, reg_wdata, cycle_q};
        end else begin
            push_entry = {1'b1, pc, mem_addr, mem_wdata, cycle_q};
        end

        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;

        level_d = level_q;
        if (push_ok && !pop) begin
            level_d = level_q + LW'(1);
        end else if (!push_ok && pop) begin
            level_d = level_q - LW'(1);
        end

        dropped_d  = dropped_q;
        overflow_d = overflow_q;
        if (push_req && !push_ok) begin
            overflow_d = 1'b1;
            if (dropped_q != 16'hFFFF) begin
                dropped_d = dropped_q + 16'd1;
            end
        end

        both_err_d = both_err_q || (trace_en && reg_we && mem_we);
        timeout_d  = timeout_q || (cycle_q == 32'(MAX_CYCLES));
        cycle_d    = (cycle_q == 32'hFFFF_FFFF) ? cycle_q : cycle_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            dropped_q  <= '0;
            cycle_q    <= '0;
            overflow_q <= 1'b0;
            both_err_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            dropped_q  <= dropped_d;
            cycle_q    <= cycle_d;
            overflow_q <= overflow_d;
            both_err_q <= both_err_d;
            timeout_q  <= timeout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && push_ok) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    // Head is forced to zero when empty so stale storage never shows on the port
    always_comb begin
        head_entry = mem_q[rd_ptr_q];
        out_valid  = (level_q != '0);
        {out_type, out_pc, out_tag, out_data, out_cycle} = out_valid ? head_entry : '0;
    end

    assign level    = level_q;
    assign dropped  = dropped_q;
    assign overflow = overflow_q;
    assign both_err = both_err_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer: a queue-based reference model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_commit_trace_buffer;
    localparam int DEPTH      = 16;
    localparam int MAX_CYCLES = 2000;
    localparam bit FILTER_X0  = 1'b1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        trace_en = 1'b0;
    logic        reg_we = 1'b0;
    logic [4:0]  reg_idx = '0;
    logic [31:0] reg_wdata = '0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] pc = '0;
    logic        out_ready = 1'b0;
    logic        out_valid, out_type, overflow, both_err, timeout;
    logic [31:0] out_pc, out_tag, out_data, out_cycle;
    logic [4:0]  level;
    logic [15:0] dropped;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    commit_trace_buffer #(
        .DEPTH(DEPTH), .MAX_CYCLES(MAX_CYCLES), .FILTER_X0(FILTER_X0)
    ) dut (
        .clk(clk), .reset(reset), .trace_en(trace_en),
        .reg_we(reg_we), .reg_idx(reg_idx), .reg_wdata(reg_wdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .pc(pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_type(out_type),
        .out_pc(out_pc), .out_tag(out_tag), .out_data(out_data), .out_cycle(out_cycle),
        .level(level), .dropped(dropped), .overflow(overflow),
        .both_err(both_err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: events as a queue of records, updated from the inputs seen at each edge
    typedef struct {
        logic        t;
        logic [31:0] pc;
        logic [31:0] tag;
        logic [31:0] data;
        logic [31:0] cyc;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_cycle = '0;
    logic [15:0] m_drop = '0;
    logic        m_ovf = 1'b0, m_both = 1'b0, m_to = 1'b0;

    always @(posedge clk) begin
        ent_t e;
        bit   req;
        if (!reset) begin
            mq.delete();
            m_cycle = '0;
            m_drop  = '0;
            m_ovf   = 1'b0;
            m_both  = 1'b0;
            m_to    = 1'b0;
        end else begin
            req = 1'b0;
            if (trace_en && reg_we && !(FILTER_X0 && reg_idx == 5'd0)) begin
                req = 1'b1;
                e = '{1'b0, pc, {27'd0, reg_idx}, reg_wdata, m_cycle};
            end else if (trace_en && mem_we) begin
                req = 1'b1;
                e = '{1'b1, pc, mem_addr, mem_wdata, m_cycle};
            end
            if (trace_en && reg_we && mem_we) m_both = 1'b1;
            if (m_cycle == 32'(MAX_CYCLES)) m_to = 1'b1;
            if (mq.size() != 0 && out_ready) begin
                $display("[TB] pop type=%0d pc=%h tag=%h data=%h cycle=%0d",
                         mq[0].t, mq[0].pc, mq[0].tag, mq[0].data, mq[0].cyc);
                mq.delete(0);
            end
            if (req) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(e);
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
                end
            end
            if (m_cycle != 32'hFFFF_FFFF) m_cycle = m_cycle + 32'd1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("valid", 32'(out_valid), 32'(mq.size() != 0));
            chk("level", 32'(level), 32'(mq.size()));
            chk("dropped", 32'(dropped), 32'(m_drop));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("both_err", 32'(both_err), 32'(m_both));
            chk("timeout", 32'(timeout), 32'(m_to));
            if (mq.size() != 0) begin
                chk("head_type", 32'(out_type), 32'(mq[0].t));
                chk("head_pc", out_pc, mq[0].pc);
                chk("head_tag", out_tag, mq[0].tag);
                chk("head_data", out_data, mq[0].data);
                chk("head_cycle", out_cycle, mq[0].cyc);
            end else begin
                chk("empty_out", out_pc | out_tag | out_data | out_cycle, 32'd0);
            end
        end
    end

    task automatic clear_inputs();
        trace_en = 1'b0; reg_we = 1'b0; mem_we = 1'b0;
        reg_idx = '0; reg_wdata = '0; mem_addr = '0; mem_wdata = '0; pc = '0;
    endtask

    task automatic drive_reg(input logic [4:0] idx, input logic [31:0] d, input logic [31:0] p);
        trace_en = 1'b1; reg_we = 1'b1; mem_we = 1'b0;
        reg_idx = idx; reg_wdata = d; pc = p;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        // Reset and idle
        reset = 1'b0;
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_level", 32'(level), 32'd0);
        chk("idle_flags", {dropped, 13'd0, overflow, both_err, timeout}, 32'd0);

        // Single REG commit stamped at cycle 5
        do_reset();
        repeat (5) @(negedge clk);
        drive_reg(5'd10, 32'd42, 32'h14);
        @(negedge clk);
        clear_inputs();
        chk("reg_valid", 32'(out_valid), 32'd1);
        chk("reg_type", 32'(out_type), 32'd0);
        chk("reg_tag", out_tag, 32'd10);
        chk("reg_data", out_data, 32'd42);
        chk("reg_pc", out_pc, 32'h14);
        chk("reg_cycle", out_cycle, 32'd5);
        repeat (3) @(negedge clk);
        chk("reg_hold", out_data, 32'd42);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("reg_popped", 32'(level), 32'd0);

        // x0 write filtered, then a store
        drive_reg(5'd0, 32'd99, 32'h20);
        @(negedge clk);
        reg_we = 1'b0; mem_we = 1'b1; mem_addr = 32'h100; mem_wdata = -32'sd7; pc = 32'h24;
        @(negedge clk);
        clear_inputs();
        chk("mem_level", 32'(level), 32'd1);
        chk("mem_type", 32'(out_type), 32'd1);
        chk("mem_tag", out_tag, 32'h100);
        chk("mem_data", out_data, 32'hFFFF_FFF9);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Overflow: 20 events into 16 entries
        for (int i = 0; i < 20; i++) begin
            drive_reg(5'(i % 31 + 1), 32'(i), 32'(i * 4));
            @(negedge clk);
        end
        clear_inputs();
        chk("ovf_level", 32'(level), 32'd16);
        chk("ovf_dropped", 32'(dropped), 32'd4);
        chk("ovf_flag", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("drain_order", out_data, 32'(i));
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk("drain_level", 32'(level), 32'd0);

        // Full with simultaneous pop and push
        for (int i = 0; i < 16; i++) begin
            drive_reg(5'd2, 32'(200 + i), 32'h40);
            @(negedge clk);
        end
        clear_inputs();
        chk("refill_level", 32'(level), 32'd16);
        out_ready = 1'b1;
        drive_reg(5'd3, 32'd300, 32'h44);
        @(negedge clk);
        clear_inputs();
        out_ready = 1'b0;
        chk("fullpop_level", 32'(level), 32'd16);
        chk("fullpop_dropped", 32'(dropped), 32'd4);
        chk("fullpop_head", out_data, 32'd201);

        // Reset in the middle of a drain
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b0;
        chk("midrst_level", 32'(level), 32'd0);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_dropped", 32'(dropped), 32'd0);

        // Simultaneous REG and MEM commit
        drive_reg(5'd3, 32'h55, 32'h48);
        mem_we = 1'b1; mem_addr = 32'h200; mem_wdata = 32'h66;
        @(negedge clk);
        clear_inputs();
        chk("both_level", 32'(level), 32'd1);
        chk("both_type", 32'(out_type), 32'd0);
        chk("both_data", out_data, 32'h55);
        chk("both_flag", 32'(both_err), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Cycle-budget timeout; capture continues afterwards
        do_reset();
        repeat (MAX_CYCLES) @(negedge clk);
        chk("to_before", 32'(timeout), 32'd0);
        drive_reg(5'd7, 32'h77, 32'h80);
        @(negedge clk);
        chk("to_set", 32'(timeout), 32'd1);
        chk("to_stamp", out_cycle, 32'(MAX_CYCLES));
        drive_reg(5'd8, 32'h88, 32'h84);
        @(negedge clk);
        clear_inputs();
        chk("to_capture", 32'(level), 32'd2);
        repeat (5) @(negedge clk);
        chk("to_sticky", 32'(timeout), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
